// File: rtl/pb_debounce_edge.sv
// Push-button conditioning: 2-flop sync, 1 kHz sampling, shift-register debounce, press/hold/release pulses.
// Build option: define PB_RELEASE_PULSE_EN to generate PB_released_o; otherwise that port is tied to zero.
module pb_debounce_edge #(
    parameter int unsigned SAMPLE_DIV   = 50000,
    parameter int unsigned DEBOUNCE_LEN = 10,
    parameter int unsigned HOLD_TICKS   = 1000
) (
    input  logic       CLOCK_50_I,
    input  logic       resetn,
    input  logic [3:0] PUSH_BUTTON_N_I,
    output logic       sample_tick_o,
    output logic [3:0] PB_status_o,
    output logic [3:0] PB_pressed_o,
    output logic [3:0] PB_held_o,
    output logic [3:0] PB_released_o
);

    localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);
    localparam logic [15:0] HOLD_MAX = 16'(HOLD_TICKS);
    localparam logic [15:0] HOLD_ARM = 16'(HOLD_TICKS - 1);

    logic [15:0]             div_cnt;
    logic                    tick;
    logic [3:0]              sync_meta;
    logic [3:0]              sync;
    logic [DEBOUNCE_LEN-1:0] sr [4];
    logic [3:0]              sr_any;
    logic [3:0]              status;
    logic [3:0]              status_buf;
    logic [15:0]             hold [4];
    logic                    held_q [4];

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    // Pads are active-low; invert before the synchronizer so everything downstream is active-high.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= ~PUSH_BUTTON_N_I;
            sync      <= sync_meta;
        end
    end

    generate
        for (genvar g = 0; g < 4; g++) begin : g_btn
            always_ff @(posedge CLOCK_50_I or negedge resetn) begin
                if (!resetn) begin
                    sr[g] <= '0;
                end else if (tick) begin
                    sr[g] <= {sr[g][DEBOUNCE_LEN-2:0], sync[g]};
                end
            end

            assign sr_any[g] = |sr[g];

            // The held pulse is raised on the same edge that moves hold to HOLD_TICKS, so it
            // appears exactly once per press; saturation blocks any repeat until status drops.
            always_ff @(posedge CLOCK_50_I or negedge resetn) begin
                if (!resetn) begin
                    hold[g]   <= '0;
                    held_q[g] <= 1'b0;
                end else begin
                    held_q[g] <= 1'b0;
                    if (!status[g]) begin
                        hold[g] <= '0;
                    end else if (tick && (hold[g] < HOLD_MAX)) begin
                        hold[g]   <= hold[g] + 16'd1;
                        held_q[g] <= (hold[g] == HOLD_ARM);
                    end
                end
            end

            assign PB_held_o[g] = held_q[g];
        end
    endgenerate

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            status     <= '0;
            status_buf <= '0;
        end else begin
            status     <= sr_any;
            status_buf <= status;
        end
    end

    assign sample_tick_o = tick;
    assign PB_status_o   = status;
    assign PB_pressed_o  = status & ~status_buf;

`ifdef PB_RELEASE_PULSE_EN
    assign PB_released_o = ~status & status_buf;
`else
    assign PB_released_o = '0;
`endif

endmodule
